// File: rtl/snake_input_pkg.sv
// Shared constants for the Snake button front end: button indices, 25 MHz timing defaults
// and a width helper used to size the per-channel counters.
package snake_input_pkg;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_LEFT  = 3;

  localparam int CLK_HZ           = 25_000_000;
  localparam int DEF_DEBOUNCE_CYC = 250_000;     // 10 ms
  localparam int DEF_REPEAT_DELAY = 12_500_000;  // 500 ms
  localparam int DEF_REPEAT_RATE  = 2_500_000;   // 100 ms

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_w(input longint unsigned v);
    int w;
    w = 0;
    while ((64'd1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, registered press/release strobes.
// Optional auto-repeat of the press strobe when BUTTON_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
  import snake_input_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int             DB_W     = clog2_w(longint'(DEBOUNCE_CYC) + 1);
  localparam logic           INACTIVE = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic            w_s;
  logic            w_flip;
  logic            w_rep_fire;

  assign w_s    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_flip = (w_s != r_level) && (r_db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= INACTIVE;
      r_sync2   <= INACTIVE;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the accepted level restarts the hold window.
      if (w_s == r_level || w_flip)
        r_db_cnt <= '0;
      else
        r_db_cnt <= r_db_cnt + 1'b1;
      r_level   <= r_level ^ w_flip;
      r_press   <= (w_flip & ~r_level) | w_rep_fire;
      r_release <= w_flip & r_level;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W    = clog2_w(longint'(REP_MAX) + 1);
  localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  logic [RP_W-1:0] r_rep_cnt;
  logic            r_rep_first;

  // A repeat never fires on the edge where the level is dropping.
  assign w_rep_fire = r_level && !w_flip &&
                      (r_rep_cnt == (r_rep_first ? RP_DELAY_LAST : RP_RATE_LAST));

  always_ff @(posedge clk) begin
    if (reset || !r_level) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  localparam logic REP_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);
  assign w_rep_fire = 1'b0 & REP_CFG_OK;
`endif

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: independent debounced channels plus an any-pressed flag.
// Define BUTTON_AUTO_REPEAT_EN to add held-button auto-repeat on btn_press.
module button_conditioner
  import snake_input_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_level
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g])
    );
  end

  assign any_level = |btn_level;

endmodule
